// File: rtl/rsa_operand_feeder.sv
// Operand feeder for the systolic array: streams A (row-major) onto Xin and
// B (column-major) onto Yin from two 1-cycle-latency read buffers, then
// pulses SA_start/done once both streams have been fully delivered.
module rsa_operand_feeder #(
    parameter int unsigned X      = 3,
    parameter int unsigned N      = 4,
    parameter int unsigned Y      = 3,
    parameter int unsigned IN_LEN = 8,
    parameter int unsigned MEM_AW = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [MEM_AW-1:0] a_base,
    input  logic [MEM_AW-1:0] b_base,
    input  logic              feed_hold,
    output logic              a_rd_en,
    output logic [MEM_AW-1:0] a_rd_addr,
    input  logic [IN_LEN-1:0] a_rd_data,
    output logic              b_rd_en,
    output logic [MEM_AW-1:0] b_rd_addr,
    input  logic [IN_LEN-1:0] b_rd_data,
    output logic              Xin_val,
    output logic [IN_LEN:1]   Xin_data,
    output logic              Yin_val,
    output logic [IN_LEN:1]   Yin_data,
    output logic              SA_start,
    output logic              busy,
    output logic              done
);

    localparam int unsigned ALen   = X * N;
    localparam int unsigned BLen   = N * Y;
    localparam int unsigned MaxLen = (ALen > BLen) ? ALen : BLen;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    localparam logic [CntW-1:0] ALenC = CntW'(ALen);
    localparam logic [CntW-1:0] BLenC = CntW'(BLen);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StKick
    } state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] a_base_q, a_base_d;
    logic [MEM_AW-1:0] b_base_q, b_base_d;
    logic [CntW-1:0]   a_cnt_q, a_cnt_d;
    logic [CntW-1:0]   b_cnt_q, b_cnt_d;
    logic              xin_val_q, xin_val_d;
    logic              yin_val_q, yin_val_d;
    logic              sa_start_q, sa_start_d;
    logic              busy_q, busy_d;

    logic a_more;
    logic b_more;

    // Next-state, counter and read-strobe logic.
    always_comb begin
        state_d  = state_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;
        a_rd_en  = 1'b0;
        b_rd_en  = 1'b0;
        a_more   = (a_cnt_q < ALenC);
        b_more   = (b_cnt_q < BLenC);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_base_d = a_base;
                    b_base_d = b_base;
                    a_cnt_d  = '0;
                    b_cnt_d  = '0;
                    state_d  = StFeed;
                end
            end
            StFeed: begin
                // Streams advance independently; hold only blocks new reads.
                a_rd_en = a_more & ~feed_hold;
                b_rd_en = b_more & ~feed_hold;
                if (a_rd_en) a_cnt_d = a_cnt_q + CntW'(1);
                if (b_rd_en) b_cnt_d = b_cnt_q + CntW'(1);
                if ((a_cnt_d >= ALenC) && (b_cnt_d >= BLenC)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StKick;
            StKick:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Valids follow the read strobes by the buffer latency.
        xin_val_d  = a_rd_en;
        yin_val_d  = b_rd_en;
        busy_d     = (state_d != StIdle);
        sa_start_d = (state_d == StKick);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            a_base_q   <= '0;
            b_base_q   <= '0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            xin_val_q  <= 1'b0;
            yin_val_q  <= 1'b0;
            sa_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            xin_val_q  <= xin_val_d;
            yin_val_q  <= yin_val_d;
            sa_start_q <= sa_start_d;
            busy_q     <= busy_d;
        end
    end

    // Addresses wrap modulo 2^MEM_AW.
    assign a_rd_addr = a_base_q + MEM_AW'(a_cnt_q);
    assign b_rd_addr = b_base_q + MEM_AW'(b_cnt_q);

    assign Xin_val  = xin_val_q;
    assign Yin_val  = yin_val_q;
    assign Xin_data = xin_val_q ? a_rd_data : '0;
    assign Yin_data = yin_val_q ? b_rd_data : '0;
    assign SA_start = sa_start_q;
    assign done     = sa_start_q;
    assign busy     = busy_q;

    // Counters never run past their stream length.
    assert property (@(posedge clk) disable iff (!sys_rst_n)
                     (a_cnt_q <= ALenC) && (b_cnt_q <= BLenC));

    // Reads are only ever issued while feeding.
    assert property (@(posedge clk) disable iff (!sys_rst_n)
                     (a_rd_en | b_rd_en) |-> (state_q == StFeed));

endmodule
